// File: rtl/my_fifo_pkg.sv
// my_fifo_pkg: shared sizing constants and count helper for the 16x4 fifo
package my_fifo_pkg;
  localparam int FIFO_WIDTH = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = 3;
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] c, input logic push, input logic pop);
    return c + CNT_W'(push) - CNT_W'(pop);
  endfunction
endpackage

// File: rtl/my_fifo_16_4_if.sv
// my_fifo_16_4_if: producer/consumer handshake bundle for the 16x4 fifo
interface my_fifo_16_4_if;
  import my_fifo_pkg::*;
  logic [FIFO_WIDTH-1:0] in;
  logic in_valid;
  logic in_ready;
  logic [FIFO_WIDTH-1:0] out;
  logic out_valid;
  logic out_ready;
  logic [CNT_W-1:0] count;
  modport master (output in, in_valid, out_ready, input in_ready, out, out_valid, count);
  modport slave (input in, in_valid, out_ready, output in_ready, out, out_valid, count);
endinterface

// File: rtl/my_mux_16_4_way.sv
// my_mux_16_4_way: 4-way 16-bit selector, sel 0..3 picks a..d
module my_mux_16_4_way (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic [15:0] c,
  input  logic [15:0] d,
  input  logic [1:0]  sel,
  output logic [15:0] y
);
  always_comb y = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/my_fifo_16_4.sv
// my_fifo_16_4: 4-deep 16-bit fifo, registered count, no same-cycle bypass
module my_fifo_16_4
  import my_fifo_pkg::*;
(
  input logic clk,
  input logic reset,
  my_fifo_16_4_if.slave bus
);
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [FIFO_WIDTH-1:0] slot [FIFO_DEPTH];
  logic [FIFO_WIDTH-1:0] head;
  logic push, pop;
  assign bus.in_ready = cnt != CNT_W'(FIFO_DEPTH);
  assign bus.out_valid = cnt != '0;
  assign bus.count = cnt;
  assign push = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;
  // head is masked to zero while empty so stale slot contents never leak out
  assign bus.out = bus.out_valid ? head : '0;
  my_mux_16_4_way u_mux (
    .a(slot[0]), .b(slot[1]), .c(slot[2]), .d(slot[3]), .sel(rd_ptr), .y(head)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= next_count(cnt, push, pop);
    end
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_slot
    always_ff @(posedge clk or posedge reset)
      if (reset) slot[g] <= '0;
      else if (push && wr_ptr == PTR_W'(g)) slot[g] <= bus.in;
  end
endmodule
